apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into single APB transfers on the apb_if signal set (pwrite, psel, pen, paddr, pwdata, pready, prdata).
- Returns read data and completion status on a valid/ready response channel.
- Sits directly upstream of the APB slave and drives it; one transfer in flight at a time.

Parameters:
- ADDR_W, 8, width of cmd_addr/paddr
- DATA_W, 8, width of cmd_wdata/pwdata/prdata/rsp_rdata
- TIMEOUT, 16, max ACCESS cycles waiting for pready before abort; must be >= 1

Ports:
- pclk  input  1  APB clock; all logic on its rising edge
- prst  input  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  input  1  command present
- cmd_ready  output  1  bridge can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_W  transfer address
- cmd_wdata  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  DATA_W  read data (0 for writes and on error)
- rsp_err  output  1  transfer aborted by timeout
- psel  output  1  APB select
- pen  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- pready  input  1  slave ready
- prdata  input  DATA_W  slave read data

Behaviour:
- Reset (prst=0, async): state IDLE; psel, pen, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0; cmd_ready=0 while reset is asserted.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No response is generated for the aborted command.
- States: IDLE, SETUP, ACCESS, RESP. All APB and response outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch pwrite=cmd_write, paddr=cmd_addr, and pwdata=cmd_wdata for writes or 0 for reads. Go to SETUP.
- SETUP (1 cycle): psel=1, pen=0. Go to ACCESS.
- ACCESS: psel=1, pen=1; paddr, pwrite and pwdata stay stable.
  - pready sampled 1: psel=0, pen=0; rsp_rdata=prdata if read, else 0; rsp_err=0; rsp_valid=1; go to RESP.
  - pready is ignored in IDLE and SETUP.
- RESP: rsp_valid, rsp_rdata and rsp_err held until rsp_ready=1. On that edge, rsp_valid=0 and go to IDLE. cmd_ready=0 throughout RESP, so there is no back-to-back overlap.
- Zero-wait latency: command accepted at edge N; SETUP during cycle N+1; ACCESS during N+2; rsp_valid=1 from cycle N+3. Each wait state adds 1 cycle.
- paddr/pwrite/pwdata hold their last values after completion until the next command is accepted.
- prdata is captured only on the completing ACCESS edge of a read.

Optional Feature:
- Macro APB_BRIDGE_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT: deassert psel/pen, set rsp_err=1, rsp_rdata=0, rsp_valid=1, go to RESP.
  - If pready=1 on the same edge the count would reach TIMEOUT, pready wins (normal completion, rsp_err=0).
- Undefined: no counter is built; ACCESS waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset: hold prst=0 for 3 cycles with cmd_valid=1 -> every output is 0 and no transfer starts; release -> cmd_ready=1 next cycle.
- Zero-wait write: addr 0x12, data 0xA5, pready tied 1 -> psel=1,pen=0 one cycle, then psel=1,pen=1 one cycle with paddr=0x12, pwdata=0xA5, pwrite=1 -> rsp_valid at N+3, rsp_rdata=0x00, rsp_err=0.
- Wait-state read: addr 0x40, slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x3C -> pen high 4 cycles, pwdata=0, rsp_rdata=0x3C at N+6.
- Response backpressure: rsp_ready=0 for 5 cycles after completion -> rsp_valid and rsp_rdata stable, cmd_ready=0, psel=0; rsp_ready=1 -> IDLE, next command accepted the following cycle.
- Timeout (macro defined, TIMEOUT=4): pready stuck 0 -> after 4 ACCESS cycles psel/pen drop, rsp_err=1, rsp_rdata=0. Boundary case: pready=1 on the 4th cycle -> rsp_err=0.
- Mid-ACCESS reset: assert prst=0 during a wait-stated write -> psel/pen drop asynchronously, no rsp_valid; the next command after release completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a valid/ready command stream into single APB transfers and returns
// read data / status on a valid/ready response channel. One transfer in flight.
// Optional macro APB_BRIDGE_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT
// cycles without pready and reports it through rsp_err. Without the macro the
// ACCESS phase waits indefinitely and rsp_err is constant 0.
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              pen,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q,      psel_d;
  logic              pen_q,       pen_d;
  logic              pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
  logic              rsp_err_q,   rsp_err_d;
`endif

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    pen_d       = pen_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // cmd_ready is registered, so the first cycle after reset refuses commands.
        if (cmd_valid && cmd_ready_q) begin
          state_d  = ST_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_SETUP: begin
        // pready is ignored here; enable goes high for the ACCESS phase.
        state_d = ST_ACCESS;
        pen_d   = 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready) begin
          // Normal completion always wins, even on the cycle the timeout would hit.
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          pen_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_BRIDGE_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else begin
`ifdef APB_BRIDGE_TIMEOUT_EN
          if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = ST_RESP;
            psel_d      = 1'b0;
            pen_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            tmo_cnt_d   = CNT_W'(TIMEOUT);
          end else begin
            tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end

      ST_RESP: begin
        // Response is held until the consumer takes it; no new command overlaps.
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          state_d     = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        pen_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      pen_q       <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      pen_q       <= pen_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef APB_BRIDGE_TIMEOUT_EN
  // Wait-state counter and error flag for the timeout abort path.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign pen       = pen_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Expected values come from the
// transfer rules (latency = 3 + wait states, read data only on completion).
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TMO = 4;

  logic          pclk;
  logic          prst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          pen;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;

  int n_cmp;
  int n_err;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One full transfer: present at current negedge, accept on next posedge (edge N).
  task automatic do_transfer(input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                             input int waits, input int hold, input string name);
    logic [DW-1:0] exp_pw;
    logic [DW-1:0] exp_rd;
    exp_pw = wr ? wdata : 8'h00;
    exp_rd = wr ? 8'h00 : rdata;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b0; rsp_ready = 1'b0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s idle_ready: got %b want 1", name, cmd_ready);
    end
    @(negedge pclk);
    // SETUP cycle; command inputs change to prove they were latched
    cmd_valid = 1'b0; cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom); cmd_write = ~wr;
    pready = 1'b1; prdata = 8'($urandom);
    n_cmp++;
    if ({psel, pen, pwrite, paddr, pwdata, cmd_ready, rsp_valid} !== {1'b1, 1'b0, wr, addr, exp_pw, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s setup: got sel=%b en=%b wr=%b a=%h d=%h rdy=%b rv=%b want 1 0 %b %h %h 0 0",
               name, psel, pen, pwrite, paddr, pwdata, cmd_ready, rsp_valid, wr, addr, exp_pw);
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge pclk);
      n_cmp++;
      if ({psel, pen, pwrite, paddr, pwdata, rsp_valid} !== {1'b1, 1'b1, wr, addr, exp_pw, 1'b0}) begin
        n_err++;
        $display("FAIL %s access%0d: got sel=%b en=%b wr=%b a=%h d=%h rv=%b want 1 1 %b %h %h 0",
                 name, i, psel, pen, pwrite, paddr, pwdata, rsp_valid, wr, addr, exp_pw);
      end
      pready = (i == waits);
      prdata = (i == waits) ? rdata : 8'($urandom);
    end
    for (int j = 0; j <= hold; j++) begin
      @(negedge pclk);
      pready = 1'b0; prdata = 8'($urandom);
      rsp_ready = (j == hold);
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel, pen, paddr, pwrite, pwdata} !==
          {1'b1, exp_rd, 1'b0, 1'b0, 1'b0, 1'b0, addr, wr, exp_pw}) begin
        n_err++;
        $display("FAIL %s resp%0d: got rv=%b rd=%h err=%b rdy=%b sel=%b en=%b a=%h want 1 %h 0 0 0 0 %h",
                 name, j, rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel, pen, paddr, exp_rd, addr);
      end
    end
    @(negedge pclk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, psel, pen, paddr, pwrite, pwdata} !== {1'b0, 1'b1, 1'b0, 1'b0, addr, wr, exp_pw}) begin
      n_err++;
      $display("FAIL %s done: got rv=%b rdy=%b sel=%b en=%b a=%h wr=%b d=%h want 0 1 0 0 %h %b %h",
               name, rsp_valid, cmd_ready, psel, pen, paddr, pwrite, pwdata, addr, wr, exp_pw);
    end
  endtask

  task automatic test_reset();
    prst = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 8'h77;
    pready = 1'b1; prdata = 8'hFF; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_cmp++;
      if ({cmd_ready, psel, pen, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== 28'h0) begin
        n_err++;
        $display("FAIL reset%0d: got rdy=%b sel=%b en=%b wr=%b a=%h d=%h rv=%b rd=%h err=%b want all 0",
                 i, cmd_ready, psel, pen, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err);
      end
    end
    prst = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0; pready = 1'b0;
    n_cmp++;
    if ({cmd_ready, psel, pen, rsp_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b sel=%b en=%b rv=%b want 1 0 0 0", cmd_ready, psel, pen, rsp_valid);
    end
  endtask

  task automatic test_zero_wait_write();
    do_transfer(1'b1, 8'h12, 8'hA5, 8'h5A, 0, 0, "zero_wait_write");
  endtask

  task automatic test_wait_read();
    do_transfer(1'b0, 8'h40, 8'hEE, 8'h3C, 3, 0, "wait_read");
  endtask

  task automatic test_backpressure();
    do_transfer(1'b0, 8'h81, 8'h00, 8'hC7, 1, 5, "backpressure");
    do_transfer(1'b1, 8'h82, 8'h19, 8'h00, 0, 0, "after_backpressure");
  endtask

  task automatic test_timeout();
`ifdef APB_BRIDGE_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h9C; cmd_wdata = 8'h00;
    pready = 1'b0; rsp_ready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge pclk);
      prdata = 8'($urandom);
      n_cmp++;
      if ({psel, pen, rsp_valid} !== 3'b110) begin
        n_err++; $display("FAIL timeout_access%0d: got sel=%b en=%b rv=%b want 1 1 0", i, psel, pen, rsp_valid);
      end
    end
    @(negedge pclk);
    rsp_ready = 1'b1;
    n_cmp++;
    if ({psel, pen, rsp_valid, rsp_err, rsp_rdata} !== {4'b0011, 8'h00}) begin
      n_err++;
      $display("FAIL timeout_abort: got sel=%b en=%b rv=%b err=%b rd=%h want 0 0 1 1 00", psel, pen, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge pclk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL timeout_done: got rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
    do_transfer(1'b0, 8'h9D, 8'h00, 8'h6B, TMO - 1, 0, "timeout_boundary");
`else
    do_transfer(1'b0, 8'h9C, 8'h00, 8'h6B, 19, 0, "no_timeout_long_wait");
`endif
  endtask

  task automatic test_mid_access_reset();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5A; cmd_wdata = 8'hC3;
    pready = 1'b0; rsp_ready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    #2 prst = 1'b0;
    #1;
    n_cmp++;
    if ({psel, pen, rsp_valid, cmd_ready, pwrite, paddr, pwdata} !== 20'h0) begin
      n_err++;
      $display("FAIL mid_reset_async: got sel=%b en=%b rv=%b rdy=%b wr=%b a=%h d=%h want all 0",
               psel, pen, rsp_valid, cmd_ready, pwrite, paddr, pwdata);
    end
    @(negedge pclk);
    prst = 1'b1; pready = 1'b1;
    @(negedge pclk);
    pready = 1'b0;
    n_cmp++;
    if ({rsp_valid, psel, pen, cmd_ready} !== 4'b0001) begin
      n_err++; $display("FAIL mid_reset_release: got rv=%b sel=%b en=%b rdy=%b want 0 0 0 1", rsp_valid, psel, pen, cmd_ready);
    end
    do_transfer(1'b1, 8'h5B, 8'h3E, 8'h00, 2, 1, "after_mid_reset");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      do_transfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_backpressure();
    test_timeout();
    test_mid_access_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
